// File: rtl/vend_txn_ctrl_pkg.sv
// Shared vending definitions: FSM state encoding, default widths and timing limits,
// and a counter-width helper used by the transaction controller.
package vend_txn_ctrl_pkg;

    localparam int CURRENCY_WIDTH_DEF  = 7;
    localparam int ITEM_ADDR_WIDTH_DEF = 10;
    localparam int TIMEOUT_CYCLES_DEF  = 1000;
    localparam int EVAL_WAIT_DEF       = 4;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_COLLECT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_LOOKUP   = 3'd2;
    localparam logic [STATE_W-1:0] ST_EVALUATE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DISPENSE = 3'd4;
    localparam logic [STATE_W-1:0] ST_REFUND   = 3'd5;

    // Width of a counter that runs from 0 up to max_count-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/credit_accum.sv
// Credit accumulator: adds accepted coins to the running credit and refuses any coin
// that would carry out of the credit register.
module credit_accum #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             add_en,
    input  logic [WIDTH-1:0] add_value,
    output logic [WIDTH-1:0] total,
    output logic [WIDTH-1:0] total_next,
    output logic             credited,
    output logic             overflow
);

    logic [WIDTH:0] sum;

    // The extra sum bit is the carry out: set means the coin does not fit.
    always_comb begin
        sum        = {1'b0, total} + {1'b0, add_value};
        overflow   = add_en & sum[WIDTH];
        credited   = add_en & ~sum[WIDTH];
        total_next = credited ? sum[WIDTH-1:0] : total;
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            total <= '0;
        end else begin
            total <= total_next;
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: collects credit, looks up price/stock for a selection,
// hands the decision to the dispense stage, drives the mechanism and pays out refunds.
module vend_txn_ctrl
    import vend_txn_ctrl_pkg::*;
#(
    parameter int CURRENCY_WIDTH  = CURRENCY_WIDTH_DEF,
    parameter int ITEM_ADDR_WIDTH = ITEM_ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int EVAL_WAIT       = EVAL_WAIT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coin_valid,
    input  logic [CURRENCY_WIDTH-1:0]  coin_value,
    output logic                       coin_reject,
    input  logic                       sel_valid,
    input  logic [ITEM_ADDR_WIDTH-1:0] sel_item,
    input  logic                       cancel,
    output logic                       lookup_req,
    output logic [ITEM_ADDR_WIDTH-1:0] lookup_addr,
    input  logic [15:0]                price_in,
    input  logic [7:0]                 avail_in,
    output logic                       selection_ready,
    output logic                       currency_ready,
    output logic [CURRENCY_WIDTH-1:0]  total_currency,
    output logic [15:0]                item_price,
    output logic [7:0]                 avail_count,
    output logic [ITEM_ADDR_WIDTH-1:0] selected_item,
    input  logic                       dispense_valid,
    input  logic [CURRENCY_WIDTH-1:0]  currency_change,
    output logic                       vend_start,
    output logic                       inv_dec,
    input  logic                       mech_done,
    output logic                       sel_denied,
    output logic                       refund_valid,
    output logic [CURRENCY_WIDTH-1:0]  refund_amount,
    input  logic                       refund_ack,
    output logic                       busy
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam int EW = cnt_width(EVAL_WAIT);

    logic [STATE_W-1:0]         state, state_n;
    logic [TW-1:0]              timer, timer_n;
    logic [EW-1:0]              eval_cnt, eval_cnt_n;
    logic [CURRENCY_WIDTH-1:0]  change_reg, change_n;
    logic [CURRENCY_WIDTH-1:0]  refund_amount_n;
    logic                       refund_valid_n;
    logic [15:0]                item_price_n;
    logic [7:0]                 avail_count_n;
    logic [ITEM_ADDR_WIDTH-1:0] selected_item_n;
    logic                       coin_reject_n;
    logic                       sel_denied_n;
    logic                       vend_n;
    logic                       vend_pulse;

    logic                       add_en;
    logic                       credit_clear;
    logic                       credited;
    logic                       overflow;
    logic [CURRENCY_WIDTH-1:0]  credit_next;

    // Coins are only taken while credit is being collected; elsewhere they bounce.
    assign add_en = coin_valid && (state == ST_IDLE || state == ST_COLLECT);

    credit_accum #(
        .WIDTH (CURRENCY_WIDTH)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .clear      (credit_clear),
        .add_en     (add_en),
        .add_value  (coin_value),
        .total      (total_currency),
        .total_next (credit_next),
        .credited   (credited),
        .overflow   (overflow)
    );

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n         = state;
        timer_n         = timer;
        eval_cnt_n      = eval_cnt;
        change_n        = change_reg;
        refund_amount_n = refund_amount;
        refund_valid_n  = refund_valid;
        item_price_n    = item_price;
        avail_count_n   = avail_count;
        selected_item_n = selected_item;
        coin_reject_n   = coin_valid && (!add_en || overflow);
        sel_denied_n    = 1'b0;
        vend_n          = 1'b0;
        credit_clear    = 1'b0;
        lookup_req      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    sel_denied_n = 1'b1;
                end
                if (credited) begin
                    if (cancel) begin
                        if (credit_next != '0) begin
                            state_n         = ST_REFUND;
                            refund_valid_n  = 1'b1;
                            refund_amount_n = credit_next;
                        end
                    end else begin
                        state_n = ST_COLLECT;
                        timer_n = '0;
                    end
                end
            end

            ST_COLLECT: begin
                if (cancel || (!credited && !sel_valid && timer == TW'(TIMEOUT_CYCLES - 1))) begin
                    // Credit includes a coin landing in the same cycle; nothing to pay means IDLE.
                    if (credit_next != '0) begin
                        state_n         = ST_REFUND;
                        refund_valid_n  = 1'b1;
                        refund_amount_n = credit_next;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (sel_valid) begin
                    lookup_req      = 1'b1;
                    selected_item_n = sel_item;
                    state_n         = ST_LOOKUP;
                end else if (credited) begin
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            ST_LOOKUP: begin
                item_price_n  = price_in;
                avail_count_n = avail_in;
                eval_cnt_n    = '0;
                state_n       = ST_EVALUATE;
            end

            ST_EVALUATE: begin
                if (dispense_valid) begin
                    change_n = currency_change;
                    vend_n   = 1'b1;
                    state_n  = ST_DISPENSE;
                end else if (eval_cnt == EW'(EVAL_WAIT - 1)) begin
                    sel_denied_n = 1'b1;
                    timer_n      = '0;
                    state_n      = ST_COLLECT;
                end else begin
                    eval_cnt_n = eval_cnt + 1'b1;
                end
            end

            ST_DISPENSE: begin
                if (mech_done) begin
                    if (change_reg != '0) begin
                        state_n         = ST_REFUND;
                        refund_valid_n  = 1'b1;
                        refund_amount_n = change_reg;
                    end else begin
                        credit_clear = 1'b1;
                        state_n      = ST_IDLE;
                    end
                end
            end

            ST_REFUND: begin
                if (refund_ack) begin
                    refund_valid_n  = 1'b0;
                    refund_amount_n = '0;
                    credit_clear    = 1'b1;
                    state_n         = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            timer         <= '0;
            eval_cnt      <= '0;
            change_reg    <= '0;
            refund_amount <= '0;
            refund_valid  <= 1'b0;
            item_price    <= '0;
            avail_count   <= '0;
            selected_item <= '0;
            coin_reject   <= 1'b0;
            sel_denied    <= 1'b0;
            vend_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            eval_cnt      <= eval_cnt_n;
            change_reg    <= change_n;
            refund_amount <= refund_amount_n;
            refund_valid  <= refund_valid_n;
            item_price    <= item_price_n;
            avail_count   <= avail_count_n;
            selected_item <= selected_item_n;
            coin_reject   <= coin_reject_n;
            sel_denied    <= sel_denied_n;
            vend_pulse    <= vend_n;
        end
    end

    // The lookup strobe is combinational so price/stock return during the single LOOKUP cycle.
    assign lookup_addr     = lookup_req ? sel_item : '0;
    assign vend_start      = vend_pulse;
    assign inv_dec         = vend_pulse;
    assign selection_ready = (state == ST_EVALUATE);
    assign currency_ready  = (state == ST_EVALUATE);
    assign busy            = (state != ST_IDLE);

endmodule
